// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational alu between two
// requesters, with valid/ready handshakes and a one-entry response register.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               drop held response, block acceptance this cycle
//   req0_*              execute-stage request (valid/ready, alucode, op1, op2)
//   req1_*              aux/addr-gen request (valid/ready, alucode, op1, op2)
//   alu_alucode/op1/op2 operands driven to the shared alu
//   alu_result/br_taken alu outputs, captured on accept
//   rsp_valid/ready     response handshake
//   rsp_id              requester that issued the held op
//   rsp_result          registered alu_result
//   rsp_br_taken        registered alu_br_taken
module alu_arbiter #(
    parameter int                XLEN      = 32,
    parameter int                CODE_W    = 6,
    parameter logic [CODE_W-1:0] IDLE_CODE = '0,
    parameter logic              PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CODE_W-1:0] req0_alucode,
    input  logic [XLEN-1:0]   req0_op1,
    input  logic [XLEN-1:0]   req0_op2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CODE_W-1:0] req1_alucode,
    input  logic [XLEN-1:0]   req1_op1,
    input  logic [XLEN-1:0]   req1_op2,
    output logic [CODE_W-1:0] alu_alucode,
    output logic [XLEN-1:0]   alu_op1,
    output logic [XLEN-1:0]   alu_op2,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_br_taken,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_result,
    output logic              rsp_br_taken
);

    logic prio;
    logic can_accept;
    logic gnt0;
    logic gnt1;
    logic accept;

    // prio only matters when both requesters contend
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | ~prio);
        gnt1 = req1_valid & (~req0_valid | prio);
    end

    assign can_accept = ~flush & (~rsp_valid | rsp_ready);
    assign req0_ready = can_accept & gnt0;
    assign req1_ready = can_accept & gnt1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Mux tracks the grant even while stalled; the result is then ignored.
    always_comb begin
        alu_alucode = IDLE_CODE;
        alu_op1     = '0;
        alu_op2     = '0;
        unique case (1'b1)
            gnt0: begin
                alu_alucode = req0_alucode;
                alu_op1     = req0_op1;
                alu_op2     = req0_op2;
            end
            gnt1: begin
                alu_alucode = req1_alucode;
                alu_op1     = req1_op1;
                alu_op2     = req1_op2;
            end
            default: ;
        endcase
    end

    // rsp_valid is the whole state: EMPTY(0) / FULL(1).
    // Flush clears only the valid bit; payload stays stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_br_taken <= 1'b0;
            prio         <= PRIO_INIT;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= gnt1;
            rsp_result   <= alu_result;
            rsp_br_taken <= alu_br_taken;
            prio         <= ~gnt1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
